// File: rtl/dds_spi_writer.sv
// rtl/dds_spi_writer.sv - runtime DDS serial-port register writer with command buffer
//
// Accepts {instruction byte, 16/32/64-bit payload} write commands once the
// init sequencer has signalled completion, buffers them, and shifts each one
// out MSB-first on SDIO/SCLK inside a CSB-low frame, optionally followed by
// an IO_UPDATE strobe.
//
// Build option: DDS_WRITER_FIFO_EN
//   defined   - FIFO_DEPTH-entry command FIFO, cmd_ready = !full
//   undefined - single holding register, cmd_ready = !busy && !holding_valid
//
// Ports:
//   TenMHzExt      system clock (posedge)
//   reset_n        asynchronous active-low reset
//   init_end_flag  pulse from the init sequencer, arms the writer (sticky)
//   cmd_valid/cmd_ready, cmd_addr[7:0], cmd_data[63:0], cmd_len[1:0],
//   cmd_update     command handshake and fields
//   SDIO, SCLK, CSB, IO_UPDATE  DDS serial port
//   busy           FSM not idle
//   done           one-cycle pulse on the last gap cycle of a transaction
module dds_spi_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 1,
    parameter int UPDATE_LEN = 5,
    parameter int GAP_LEN    = 2
) (
    input  logic        TenMHzExt,
    input  logic        reset_n,
    input  logic        init_end_flag,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_addr,
    input  logic [63:0] cmd_data,
    input  logic [1:0]  cmd_len,
    input  logic        cmd_update,
    output logic        SDIO,
    output logic        SCLK,
    output logic        CSB,
    output logic        IO_UPDATE,
    output logic        busy,
    output logic        done
);

    // Entry layout: {update, len[1:0], addr[7:0], data[63:0]}
    localparam int EW   = 75;
    localparam int PW   = $clog2(2 * CLK_DIV + 1);
    localparam int TMAX = (CLK_DIV > UPDATE_LEN)
                        ? ((CLK_DIV > GAP_LEN) ? CLK_DIV : GAP_LEN)
                        : ((UPDATE_LEN > GAP_LEN) ? UPDATE_LEN : GAP_LEN);
    localparam int TW   = $clog2(TMAX + 1);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || CLK_DIV < 1 || UPDATE_LEN < 1 || GAP_LEN < 1) begin : g_bad_params
        $error("dds_spi_writer: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_HOLD,
        S_UPDATE,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [71:0]     shreg_q, shreg_d;
    logic [6:0]      bit_q, bit_d;
    logic [6:0]      last_q, last_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            upd_q, upd_d;
    logic            armed_q;

    logic [EW-1:0]   cmd_entry;
    logic [EW-1:0]   head;
    logic            head_valid;
    logic            push;
    logic            pop;

    assign cmd_entry = {cmd_update, cmd_len, cmd_addr, cmd_data};
    assign push      = cmd_valid && cmd_ready;

`ifdef DDS_WRITER_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    // Depth is a power of two, so the pointers wrap by natural overflow.
    assign cmd_ready  = (count_q != (AW + 1)'(FIFO_DEPTH));
    assign head_valid = (count_q != '0);
    assign head       = mem_q[rd_ptr_q];

    always_ff @(posedge TenMHzExt or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge TenMHzExt) begin
        if (push) mem_q[wr_ptr_q] <= cmd_entry;
    end
`else
    logic [EW-1:0] hold_q;
    logic          hold_valid_q;

    assign cmd_ready  = (state_q == S_IDLE) && !hold_valid_q;
    assign head_valid = hold_valid_q;
    assign head       = hold_q;

    always_ff @(posedge TenMHzExt or negedge reset_n) begin
        if (!reset_n) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else if (push) begin
            hold_q       <= cmd_entry;
            hold_valid_q <= 1'b1;
        end else if (pop) begin
            hold_valid_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge TenMHzExt or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            last_q  <= '0;
            phase_q <= '0;
            tmr_q   <= '0;
            upd_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            phase_q <= phase_d;
            tmr_q   <= tmr_d;
            upd_q   <= upd_d;
            armed_q <= armed_q | init_end_flag;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        last_d  = last_q;
        phase_d = phase_q;
        tmr_d   = tmr_q;
        upd_d   = upd_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (armed_q && head_valid) begin
                    pop     = 1'b1;
                    upd_d   = head[74];
                    bit_d   = '0;
                    phase_d = '0;
                    state_d = S_SHIFT;
                    // Left-justify {addr, payload} so the MSB is always shreg[71].
                    case (head[73:72])
                        2'd0: begin
                            shreg_d = {head[71:64], head[15:0], 48'd0};
                            last_d  = 7'd23;
                        end
                        2'd1: begin
                            shreg_d = {head[71:64], head[31:0], 32'd0};
                            last_d  = 7'd39;
                        end
                        default: begin
                            shreg_d = head[71:0];
                            last_d  = 7'd71;
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                // Shift at the end of the high phase so SDIO only moves while SCLK is low.
                if (phase_q == PW'(2 * CLK_DIV - 1)) begin
                    phase_d = '0;
                    if (bit_q == last_q) begin
                        tmr_d   = '0;
                        state_d = S_HOLD;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = {shreg_q[70:0], 1'b0};
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (tmr_q == TW'(CLK_DIV - 1)) begin
                    tmr_d   = '0;
                    state_d = upd_q ? S_UPDATE : S_GAP;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_UPDATE: begin
                if (tmr_q == TW'(UPDATE_LEN - 1)) begin
                    tmr_d   = '0;
                    state_d = S_GAP;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_GAP: begin
                if (tmr_q == TW'(GAP_LEN - 1)) begin
                    tmr_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign CSB       = !((state_q == S_SHIFT) || (state_q == S_HOLD));
    assign SCLK      = (state_q == S_SHIFT) && (phase_q >= PW'(CLK_DIV));
    assign SDIO      = (state_q == S_SHIFT) && shreg_q[71];
    assign IO_UPDATE = (state_q == S_UPDATE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_GAP) && (tmr_q == TW'(GAP_LEN - 1));

endmodule

// File: doc/dds_spi_writer.md
# dds_spi_writer

Runtime register writer for the DDS serial port, downstream of the power-up initialization sequencer. After initialization completes, it accepts write commands (instruction byte plus 16/32/64-bit payload) from the control logic and buffers them in a small FIFO. It shifts each command out MSB-first on SDIO/SCLK with CSB framing, then optionally pulses IO_UPDATE so the DDS latches the new register contents.

## Interface
Parameters:
- FIFO_DEPTH, 4: command buffer entries (power of two, 2..16).
- CLK_DIV, 1: TenMHzExt cycles per SCLK half-period (≥1).
- UPDATE_LEN, 5: IO_UPDATE pulse width in cycles (≥1).
- GAP_LEN, 2: minimum CSB-high cycles between transactions (≥1).

Ports (one clock; reset is asynchronous and active-low):
- TenMHzExt  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- init_end_flag  in  1  one-cycle pulse from the init sequencer; arms the writer (sticky).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; transfer on valid&ready at posedge.
- cmd_addr  in  8  DDS instruction byte.
- cmd_data  in  64  payload, LSB-justified.
- cmd_len  in  2  0: 16-bit, 1: 32-bit, 2 or 3: 64-bit payload.
- cmd_update  in  1  pulse IO_UPDATE after this write.
- SDIO  out  1  serial data.
- SCLK  out  1  serial clock.
- CSB  out  1  chip select, active low.
- IO_UPDATE  out  1  DDS update strobe.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse at the end of each transaction.

## Operation
- Reset values: SDIO=0, SCLK=0, CSB=1, IO_UPDATE=0, busy=0, done=0, armed=0, FIFO empty, cmd_ready=1.
- armed is set by init_end_flag and cleared only by reset. Commands can be queued while unarmed; none are popped until armed.
- FSM states: IDLE → SHIFT → HOLD → (UPDATE if the entry's update bit is set) → GAP → IDLE.
- IDLE: if armed and FIFO not empty, pop the head entry and load the shift register with {addr, data[N-1:0]}, where N = 16/32/64. Bit count = 8+N. Go to SHIFT.
- SHIFT: CSB=0. Each bit takes 2·CLK_DIV cycles: SCLK low for CLK_DIV cycles with SDIO already presenting the bit, then SCLK high for CLK_DIV cycles. SDIO changes only while SCLK is low. The DDS samples on the SCLK rising edge. After the high phase of the last bit, go to HOLD.
- HOLD: SCLK=0, SDIO=0, CSB=0 for CLK_DIV cycles, then CSB=1.
- UPDATE: IO_UPDATE=1 for exactly UPDATE_LEN cycles.
- GAP: CSB=1 for GAP_LEN cycles. done pulses on the last GAP cycle.
- FIFO rules: cmd_ready = !full, registered from the occupancy count. A push and a pop in the same cycle leave the count unchanged. A pop from a full FIFO raises cmd_ready on the next cycle. Pointers wrap modulo FIFO_DEPTH.
- Asserting reset_n mid-transaction immediately returns all outputs to their reset values, flushes the FIFO, and clears armed. No partial frame resumes.

## Timing
- Pop at posedge k: CSB falls and the first SDIO bit appears at k+1.
- Frame length (CSB low) = (8+N)·2·CLK_DIV + CLK_DIV cycles. CSB rises at k+1+frame.
- With update set, IO_UPDATE is high for cycles [CSB-rise, CSB-rise+UPDATE_LEN-1]. GAP follows.
- Back-to-back queued commands: the next CSB fall comes exactly GAP_LEN cycles after the previous GAP starts, plus 1 IDLE cycle.
- Push-to-SDIO latency from an empty, armed, idle FIFO: 2 cycles (write at k, pop at k+1, CSB low at k+2).

## Configuration
- DDS_WRITER_FIFO_EN defined: FIFO_DEPTH-entry buffer as described.
- DDS_WRITER_FIFO_EN undefined: single holding register. cmd_ready = !busy && !holding_valid. FIFO_DEPTH is ignored. Behaviour is otherwise identical.

## Test plan
- Reset, then a 32-bit command (addr 8'h07, data 32'h12345678, update=1) queued before init_end_flag → no CSB activity. After the init_end_flag pulse, CSB is low for 81 cycles (CLK_DIV=1), 40 SDIO bits 0x07_12345678 are sampled on SCLK rises, IO_UPDATE is high for 5 cycles, then done.
- 16-bit (addr 8'h0E, data 16'hABCD, update=0) → 24 bits, CSB low 49 cycles, IO_UPDATE stays 0.
- 64-bit (cmd_len=3, data 64'h0123456789ABCDEF) with CLK_DIV=3 → 72 bits, SCLK period 6 cycles, CSB low 435 cycles.
- Push 5 commands back-to-back with FIFO_DEPTH=4 and armed=0 → cmd_ready falls after the 4th. After arming, all 4 are sent in order with ≥2 CSB-high cycles between frames. The 5th is accepted the cycle after the first pop frees a slot.
- Assert reset_n mid-SHIFT → CSB=1, SCLK=0, SDIO=0 immediately. FIFO empty and no frames after release until a new init_end_flag and command.
